// File: rtl/frame_scan_controller.sv
// frame_scan_controller: sweeps one 160x120 redraw, snapshots game state,
// and delays coordinates/plot to line up with the colour generator.
module frame_scan_controller #(
  parameter int H_PIXELS = 160,
  parameter int V_PIXELS = 120,
  parameter int PIPE_LAT = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_req,
  input  logic [3:0] state_in,
  input  logic [7:0] pX_in,
  input  logic [7:0] gX_in,
  input  logic [6:0] pY_in,
  input  logic [6:0] gY_in,
  output logic [7:0] X,
  output logic [6:0] Y,
  output logic [3:0] state,
  output logic [7:0] pX,
  output logic [7:0] gX,
  output logic [6:0] pY,
  output logic [6:0] gY,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic       plot,
  output logic       frame_busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } fsm_t;

  localparam logic [7:0] XLAST = 8'(H_PIXELS - 1);
  localparam logic [6:0] YLAST = 7'(V_PIXELS - 1);

  fsm_t cur, nxt;
  logic [7:0] x_n;
  logic [6:0] y_n;
  logic       load;
  logic       inflight;

  logic [PIPE_LAT-1:0] vld_q;
  logic [7:0]          px_q [PIPE_LAT];
  logic [6:0]          py_q [PIPE_LAT];

  // any valid pixel that will still be in the pipe after this edge
  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < PIPE_LAT - 1; i++) begin
      inflight = inflight | vld_q[i];
    end
  end

  // next state, next scan position, snapshot load
  always_comb begin
    nxt  = cur;
    x_n  = X;
    y_n  = Y;
    load = 1'b0;
    unique case (cur)
      IDLE: begin
        x_n = '0;
        y_n = '0;
        if (frame_req) begin
          load = 1'b1;
          nxt  = SCAN;
        end
      end
      SCAN: begin
        if (X == XLAST) begin
          x_n = '0;
          if (Y == YLAST) begin
            y_n = '0;
            nxt = DRAIN;
          end else begin
            y_n = Y + 7'd1;
          end
        end else begin
          x_n = X + 8'd1;
        end
      end
      DRAIN: begin
        x_n = '0;
        y_n = '0;
        if (!inflight) nxt = DONE;
      end
      DONE: begin
        x_n = '0;
        y_n = '0;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // FSM and scan counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur <= IDLE;
      X   <= '0;
      Y   <= '0;
    end else begin
      cur <= nxt;
      X   <= x_n;
      Y   <= y_n;
    end
  end

  // frame-start snapshot of live game state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= '0;
      pX    <= '0;
      pY    <= '0;
      gX    <= '0;
      gY    <= '0;
    end else if (load) begin
      state <= state_in;
      pX    <= pX_in;
      pY    <= pY_in;
      gX    <= gX_in;
      gY    <= gY_in;
    end
  end

  // delay line matching generator latency; shifts every cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
    end else begin
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        px_q[i]  <= px_q[i-1];
        py_q[i]  <= py_q[i-1];
      end
      vld_q[0] <= (cur == SCAN);
      px_q[0]  <= X;
      py_q[0]  <= Y;
    end
  end

  assign plot       = vld_q[PIPE_LAT-1];
  assign vga_x      = px_q[PIPE_LAT-1];
  assign vga_y      = py_q[PIPE_LAT-1];
  assign frame_busy = (cur == SCAN) || (cur == DRAIN);
  assign frame_done = (cur == DONE);

endmodule

// File: tb/tb_frame_scan_controller.sv
// tb_frame_scan_controller: directed sequence with random live inputs,
// checked every cycle against a frame-offset arithmetic model.
module tb_frame_scan_controller;

  localparam int H = 160;
  localparam int V = 120;
  localparam int L = 2;
  localparam int F = H * V;

  logic       clock;
  logic       reset;
  logic       frame_req;
  logic [3:0] state_in;
  logic [7:0] pX_in, gX_in;
  logic [6:0] pY_in, gY_in;
  logic [7:0] X, pX, gX, vga_x;
  logic [6:0] Y, pY, gY, vga_y;
  logic [3:0] state;
  logic       plot, frame_busy, frame_done;

  frame_scan_controller #(
    .H_PIXELS(H),
    .V_PIXELS(V),
    .PIPE_LAT(L)
  ) dut (
    .clock(clock),
    .reset(reset),
    .frame_req(frame_req),
    .state_in(state_in),
    .pX_in(pX_in),
    .gX_in(gX_in),
    .pY_in(pY_in),
    .gY_in(gY_in),
    .X(X),
    .Y(Y),
    .state(state),
    .pX(pX),
    .gX(gX),
    .pY(pY),
    .gY(gY),
    .vga_x(vga_x),
    .vga_y(vga_y),
    .plot(plot),
    .frame_busy(frame_busy),
    .frame_done(frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // model: d = edges since the accepting edge
  int   ecnt = 0;
  int   d = 0;
  bit   active = 1'b0;
  logic [3:0] m_state;
  logic [7:0] m_px, m_gx;
  logic [6:0] m_py, m_gy;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      active  = 1'b0;
      d       = 0;
      m_state = '0;
      m_px    = '0;
      m_gx    = '0;
      m_py    = '0;
      m_gy    = '0;
    end else begin
      ecnt++;
      if (!active || d >= F + L + 1) begin
        if (frame_req) begin
          active  = 1'b1;
          d       = 0;
          m_state = state_in;
          m_px    = pX_in;
          m_gx    = gX_in;
          m_py    = pY_in;
          m_gy    = gY_in;
        end
      end else begin
        d++;
      end
    end
  end

  // observed-timing monitor
  int rises[$];
  int mon_rise, mon_first, mon_last, mon_cnt, mon_done;
  int done_cnt = 0;
  bit prev_busy = 1'b0;
  bit rand_live = 1'b0;
  bit rand_req = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    logic eb, ed, ep;
    logic [7:0] ex, evx;
    logic [6:0] ey, evy;
    eb  = active && d < F + L;
    ed  = active && d == F + L;
    ep  = active && d >= L && d < F + L;
    ex  = '0;
    ey  = '0;
    evx = '0;
    evy = '0;
    if (active && d < F) begin
      ex = 8'(d % H);
      ey = 7'(d / H);
    end
    if (ep) begin
      evx = 8'((d - L) % H);
      evy = 7'((d - L) / H);
    end
    chk("busy", 64'(frame_busy), 64'(eb));
    chk("done", 64'(frame_done), 64'(ed));
    chk("plot", 64'(plot), 64'(ep));
    chk("xy", 64'({X, Y}), 64'({ex, ey}));
    if (ep) chk("vga", 64'({vga_x, vga_y}), 64'({evx, evy}));
    chk("snap", 64'({state, pX, pY, gX, gY}),
        64'({m_state, m_px, m_py, m_gx, m_gy}));
    if (frame_busy && !prev_busy) begin
      rises.push_back(ecnt);
      mon_rise  = ecnt;
      mon_first = -1;
      mon_cnt   = 0;
    end
    if (plot) begin
      if (mon_first < 0) mon_first = ecnt;
      mon_last = ecnt;
      mon_cnt++;
    end
    if (frame_done) begin
      mon_done = ecnt;
      done_cnt++;
    end
    prev_busy = frame_busy;
  endtask

  task automatic tick();
    @(negedge clock);
    check_cycle();
    if (rand_live) begin
      state_in = 4'($urandom);
      pX_in    = 8'($urandom);
      gX_in    = 8'($urandom);
      pY_in    = 7'($urandom);
      gY_in    = 7'($urandom);
    end
    if (rand_req) frame_req = ($urandom_range(0, 40) == 0);
  endtask

  task automatic wait_d(input int target, input int limit, input string tag);
    for (int i = 0; i < limit && !(active && d == target); i++) tick();
    chk(tag, 64'(active && d == target), 64'd1);
  endtask

  initial begin
    int dc;
    reset     = 1'b1;
    frame_req = 1'b0;
    state_in  = 4'b0001;
    pX_in     = 8'd0;
    gX_in     = 8'd0;
    pY_in     = 7'd0;
    gY_in     = 7'd0;
    repeat (3) tick();
    chk("rst_out", 64'({X, Y, vga_x, vga_y, plot, frame_busy, frame_done}), 64'd0);
    chk("rst_snap", 64'({state, pX, pY, gX, gY}), 64'd0);
    reset = 1'b0;
    repeat (5) tick();

    // frame 1: snapshot hold, row wrap, ignored requests
    state_in  = 4'b0010;
    pX_in     = 8'd40;
    pY_in     = 7'd30;
    gX_in     = 8'd100;
    gY_in     = 7'd90;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    repeat (5) tick();
    pX_in = 8'd41;
    wait_d(159, 400, "reach_159");
    chk("pre_wrap", 64'({X, Y}), 64'({8'd159, 7'd0}));
    tick();
    chk("wrap", 64'({X, Y}), 64'({8'd0, 7'd1}));
    repeat (L) tick();
    chk("wrap_vga", 64'({plot, vga_x, vga_y}), 64'({1'b1, 8'd0, 7'd1}));
    rand_live = 1'b1;
    rand_req  = 1'b1;
    repeat (15000) tick();
    rand_req  = 1'b0;
    frame_req = 1'b0;
    wait_d(F + L, 6000, "reach_done");
    chk("hold_pX", 64'(pX), 64'd40);
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    repeat (20) tick();
    chk("first_plot", 64'(mon_first - mon_rise), 64'(L));
    chk("last_plot", 64'(mon_last - mon_rise), 64'(F - 1 + L));
    chk("done_at", 64'(mon_done - mon_rise), 64'(F + L));
    chk("plot_cnt", 64'(mon_cnt), 64'(F));
    chk("no_restart", 64'(rises.size()), 64'd1);
    chk("idle_busy", 64'(frame_busy), 64'd0);
    chk("idle_pX", 64'(pX), 64'd40);

    // frame 2: reset at pixel (80,60)
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    wait_d(60 * H + 80, 12000, "reach_mid");
    chk("mid_xy", 64'({X, Y}), 64'({8'd80, 7'd60}));
    dc    = done_cnt;
    reset = 1'b1;
    #1;
    chk("rst_mid", 64'({plot, frame_busy, X, Y}), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    repeat (50) tick();
    chk("no_done", 64'(done_cnt), 64'(dc));
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    chk("restart", 64'({frame_busy, X, Y}), 64'({1'b1, 8'd0, 7'd0}));
    repeat (L + 3) tick();
    chk("restart_vga", 64'({plot, vga_x, vga_y}), 64'({1'b1, 8'd3, 7'd0}));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // back-to-back frames with request held high
    rises.delete();
    frame_req = 1'b1;
    for (int i = 0; i < 40000 && rises.size() < 2; i++) tick();
    chk("two_starts", 64'(rises.size() >= 2), 64'd1);
    if (rises.size() >= 2)
      chk("period", 64'(rises[1] - rises[0]), 64'(F + 2 + L));
    frame_req = 1'b0;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_scan_controller.md
# frame_scan_controller

Sequences one full-screen redraw of the 160×120, 3-bit-colour display. It sweeps pixel coordinates into the output generator and snapshots game state plus Pac-Man/ghost positions at frame start, so sprites never tear mid-frame. It also delays coordinates and a plot strobe to match the generator's ROM-plus-register latency, so the VGA adapter writes each colour to the correct pixel. It sits between the game logic (frame requests, live positions) and the output generator / VGA adapter pair.

## Interface
- H_PIXELS, 160, pixels per row
- V_PIXELS, 120, rows per frame
- PIPE_LAT, 2, cycles from X/Y presented to colour valid at generator output (≥1)

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_req  in  1  request one redraw; sampled only in IDLE
- state_in  in  4  live game state (001 start, 010 play, 100 lose, 111 win)
- pX_in, gX_in  in  8  live Pac-Man / ghost X
- pY_in, gY_in  in  7  live Pac-Man / ghost Y
- X  out  8  scan column to generator
- Y  out  7  scan row to generator
- state  out  4  snapshot of state_in
- pX, gX  out  8  snapshot of pX_in, gX_in
- pY, gY  out  7  snapshot of pY_in, gY_in
- vga_x  out  8  X delayed by PIPE_LAT
- vga_y  out  7  Y delayed by PIPE_LAT
- plot  out  1  write strobe to VGA adapter, aligned with vga_x/vga_y and generator colour
- frame_busy  out  1  high in SCAN and DRAIN
- frame_done  out  1  one-cycle pulse when the last pixel has been plotted

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE: X=Y=0, no valid pixel issued.
  - frame_req=1 at an edge loads the snapshot registers (state, pX, pY, gX, gY) from the *_in ports, sets X=Y=0, and moves to SCAN.
- SCAN: every cycle presents one valid pixel.
  - Each edge: X+1, except at X=H_PIXELS-1, where X wraps to 0 and Y+1.
  - At X=H_PIXELS-1, Y=V_PIXELS-1: go to DRAIN; X and Y return to 0.
- DRAIN: no new pixels issued. Stay until the valid pipeline is empty, then go to DONE.
- DONE: frame_done=1 for exactly one cycle, then IDLE.
- Pipeline:
  - PIPE_LAT-stage shift registers carry valid, X and Y.
  - plot = valid at the last stage; vga_x/vga_y = last-stage X/Y.
  - Stages shift every cycle, regardless of FSM state.
- Snapshot registers change only on the IDLE→SCAN edge. They hold their values through DONE/IDLE until the next accepted request.
- frame_req is ignored in SCAN, DRAIN and DONE. It is not queued.
- Width rules:
  - X is 8 bits and never exceeds H_PIXELS-1.
  - Y is 7 bits and never exceeds V_PIXELS-1.
  - No out-of-range coordinate ever reaches vga_x/vga_y with plot=1.

## Timing
- Reset (asynchronous, any time):
  - FSM→IDLE.
  - X, Y, vga_x, vga_y, plot, frame_busy, frame_done = 0.
  - All snapshot outputs = 0.
  - Pipeline valid bits cleared.
  - Reset mid-frame drops plot in the same cycle; no completion pulse follows.
- Edge n samples frame_req=1 in IDLE:
  - From n+1: frame_busy=1, X=0, Y=0, snapshot valid.
  - First plot (vga_x=0, vga_y=0): cycle n+1+PIPE_LAT.
  - Pixel k (k = Y·160+X) is plotted in cycle n+1+PIPE_LAT+k.
  - Last plot (159,119): cycle n+19200+PIPE_LAT.
  - frame_done=1 and frame_busy=0: cycle n+19201+PIPE_LAT.
  - IDLE from cycle n+19202+PIPE_LAT.
- plot is high for exactly H_PIXELS·V_PIXELS consecutive cycles per frame, with no gaps.
- Earliest back-to-back start: frame_req held high is accepted again at the edge ending IDLE's first cycle. Frame period = 19202+PIPE_LAT cycles.
- Live input changes during SCAN/DRAIN have no effect on the snapshot outputs.

## Test plan
- Reset, then one frame_req pulse at edge 10, PIPE_LAT=2:
  - First plot at cycle 13 with (0,0).
  - Last plot at cycle 19212 with (159,119).
  - frame_done only at 19213.
  - Exactly 19200 plot cycles in total.
- Row wrap: at the pixel after (159,0), X=0 and Y=1. vga_x/vga_y track X/Y with exactly 2 cycles of lag.
- Snapshot hold: start a frame with pX_in=40, pY_in=30; change pX_in to 41 after 5 cycles. pX stays 40 until frame_done, then stays 40 through IDLE.
- frame_req pulsed mid-SCAN and in the DONE cycle: no second frame starts; frame_busy stays low after DONE.
- Assert reset at pixel (80,60): plot, frame_busy, X and Y are 0 immediately. No frame_done occurs. A new frame_req then restarts at (0,0).
- frame_req held high continuously: consecutive frames start 19204 cycles apart (PIPE_LAT=2). Snapshot is re-latched each frame.
